// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle for skid_buffer: upstream write side, downstream read side.
// flush exists only when SKID_FLUSH_EN is defined.
interface skid_buffer_if #(
    parameter int Width = 32
);
    logic             wr_valid;
    logic [Width-1:0] wr_data;
    logic             wr_ready;
    logic             rd_ready;
    logic [Width-1:0] rd_data;
    logic             rd_valid;
`ifdef SKID_FLUSH_EN
    logic             flush;
`endif

    // Buffer side: accepts writes, presents the head beat.
    modport slave (
        input  wr_valid, wr_data, rd_ready,
`ifdef SKID_FLUSH_EN
        input  flush,
`endif
        output wr_ready, rd_data, rd_valid
    );

    // Environment side: produces writes, consumes reads.
    modport master (
        output wr_valid, wr_data, rd_ready,
`ifdef SKID_FLUSH_EN
        output flush,
`endif
        input  wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry elastic stage with every output (wr_ready, rd_valid, rd_data) taken straight from a flop.
// Define SKID_FLUSH_EN to add a synchronous flush that empties the buffer.
module skid_buffer #(
    parameter int Width = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    skid_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_fire, rd_fire;

    assign wr_fire = bus.wr_valid && wr_ready_q;
    assign rd_fire = rd_valid_q && bus.rd_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (wr_fire) begin
                    main_d  = bus.wr_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wr_fire && rd_fire) begin
                    main_d = bus.wr_data;
                end else if (wr_fire) begin
                    // Downstream stalled while a beat landed: park it behind the head.
                    skid_d  = bus.wr_data;
                    state_d = FULL;
                end else if (rd_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (rd_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef SKID_FLUSH_EN
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
        wr_ready_d = (state_d != FULL);
        rd_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = main_q;
endmodule
